// File: rtl/piccolo_round_engine.sv
// piccolo_round_engine: iterative Piccolo datapath, one round per clock.
// Optional decryption port `dec` is enabled by PICCOLO_ROUND_ENGINE_DEC_EN.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input handshake; in_data plaintext, wk whitening keys
//   rk_round / rk         round index to key schedule, round keys back
//   out_valid/out_ready   output handshake; out_data ciphertext
//   dec                   (macro only) 1 = decrypt, sampled on accept

module piccolo_roundpermutation (
   input  logic [63:0] in_data,
   output logic [63:0] out_data
);
   // Byte shuffle (b0..b7) -> (b2,b7,b4,b1,b6,b3,b0,b5), b0 = MSB byte
   assign out_data = {in_data[47:40], in_data[7:0],
                      in_data[31:24], in_data[55:48],
                      in_data[15:8],  in_data[39:32],
                      in_data[63:56], in_data[23:16]};
endmodule

module piccolo_round_engine #(
   parameter int ROUNDS = 25
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   input  logic [63:0] wk,
`ifdef PICCOLO_ROUND_ENGINE_DEC_EN
   input  logic        dec,
`endif
   output logic [4:0]  rk_round,
   input  logic [31:0] rk,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data
);

   localparam logic [4:0] LAST = 5'(ROUNDS - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   function automatic logic [3:0] sbox(input logic [3:0] a);
      logic [3:0] r;
      unique case (a)
         4'h0: r = 4'he;
         4'h1: r = 4'h4;
         4'h2: r = 4'hb;
         4'h3: r = 4'h2;
         4'h4: r = 4'h3;
         4'h5: r = 4'h8;
         4'h6: r = 4'h0;
         4'h7: r = 4'h9;
         4'h8: r = 4'h1;
         4'h9: r = 4'ha;
         4'ha: r = 4'h7;
         4'hb: r = 4'hf;
         4'hc: r = 4'h6;
         4'hd: r = 4'hc;
         4'he: r = 4'h5;
         4'hf: r = 4'hd;
      endcase
      return r;
   endfunction

   // Multiply by x in GF(2^4), x^4+x+1
   function automatic logic [3:0] xt(input logic [3:0] a);
      return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
   endfunction

   function automatic logic [15:0] f_fn(input logic [15:0] x);
      logic [3:0] s0, s1, s2, s3;
      logic [3:0] m0, m1, m2, m3;
      s0 = sbox(x[15:12]);
      s1 = sbox(x[11:8]);
      s2 = sbox(x[7:4]);
      s3 = sbox(x[3:0]);
      m0 = xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3;
      m1 = s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3;
      m2 = s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3;
      m3 = xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3);
      return {sbox(m0), sbox(m1), sbox(m2), sbox(m3)};
   endfunction

   state_t      state;
   logic [63:0] x_q;
   logic [31:0] fin_q;
   logic        dec_sel;
   logic        dec_on;
   logic        last;
   logic        swap;
   logic [15:0] rk_a;
   logic [15:0] rk_b;
   logic [63:0] y;
   logic [63:0] y_perm;

`ifdef PICCOLO_ROUND_ENGINE_DEC_EN
   logic dec_q;
   assign dec_sel = dec;
   assign dec_on  = dec_q;
`else
   assign dec_sel = 1'b0;
   assign dec_on  = 1'b0;
`endif

   assign in_ready = (state == IDLE);

   assign last = dec_on ? (rk_round == 5'd0)
                        : (rk_round == LAST);

   // Decrypt step count is LAST - rk_round; its parity
   // is LAST[0] ^ rk_round[0].
   assign swap = dec_on & (LAST[0] ^ rk_round[0]);

   assign rk_a = swap ? rk[15:0] : rk[31:16];
   assign rk_b = swap ? rk[31:16] : rk[15:0];

   assign y = {x_q[63:48],
               x_q[47:32] ^ f_fn(x_q[63:48]) ^ rk_a,
               x_q[31:16],
               x_q[15:0] ^ f_fn(x_q[31:16]) ^ rk_b};

   piccolo_roundpermutation u_rp (
      .in_data  (y),
      .out_data (y_perm)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         x_q       <= '0;
         fin_q     <= '0;
         rk_round  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
`ifdef PICCOLO_ROUND_ENGINE_DEC_EN
         dec_q     <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  if (dec_sel) begin
                     x_q <= {in_data[63:48] ^ wk[31:16],
                             in_data[47:32],
                             in_data[31:16] ^ wk[15:0],
                             in_data[15:0]};
                     fin_q    <= wk[63:32];
                     rk_round <= LAST;
                  end else begin
                     x_q <= {in_data[63:48] ^ wk[63:48],
                             in_data[47:32],
                             in_data[31:16] ^ wk[47:32],
                             in_data[15:0]};
                     fin_q    <= wk[31:0];
                     rk_round <= 5'd0;
                  end
`ifdef PICCOLO_ROUND_ENGINE_DEC_EN
                  dec_q <= dec_sel;
`endif
                  state <= RUN;
               end
            end
            RUN: begin
               if (last) begin
                  out_data <= {y[63:48] ^ fin_q[31:16],
                               y[47:32],
                               y[31:16] ^ fin_q[15:0],
                               y[15:0]};
                  out_valid <= 1'b1;
                  rk_round  <= 5'd0;
                  state     <= DONE;
               end else begin
                  x_q      <= y_perm;
                  rk_round <= dec_on ? rk_round - 5'd1
                                     : rk_round + 5'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/piccolo_round_engine.md
Name: piccolo_round_engine

Overview:
- Iterative Piccolo encryption datapath, one round per clock, on a 64-bit state register.
- Sits directly upstream of the Roundpermutation block. It computes whitening, the F-function and round-key addition each cycle, then feeds the result through an internal Roundpermutation instance before writing it back to the state register.
- Round keys come combinationally from the external key-schedule block, indexed by rk_round. Whitening keys are presented with the input block.

Parameters:
- ROUNDS, 25, number of rounds (25 for Piccolo-80, 31 for Piccolo-128); legal range 2..31.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input block valid
- in_ready  output  1  engine can accept a block (high only in IDLE)
- in_data  input  64  plaintext; X0=[63:48], X1=[47:32], X2=[31:16], X3=[15:0]
- wk  input  64  whitening keys {wk0,wk1,wk2,wk3}, 16 bits each, wk0 at [63:48]; sampled only on the accept edge
- rk_round  output  5  current round index i, for the key schedule
- rk  input  32  {rk_2i,rk_2i+1} for round rk_round; rk_2i at [31:16]; sampled on every RUN edge
- out_valid  output  1  ciphertext valid
- out_ready  input  1  downstream accepts ciphertext
- out_data  output  64  ciphertext, same word order as in_data

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE; state register, wk3-final latch, rk_round, out_valid and out_data all go to 0.
  - in_ready is 1 once rst_n deasserts.
  - Assertion mid-operation aborts the block with no output.
- F(x), 16 bits, is defined as S(M(S(x))):
  - S = four parallel 4-bit S-boxes {e,4,b,2,3,8,0,9,1,a,7,f,6,c,5,d}.
  - M = the matrix [[2,3,1,1],[1,2,3,1],[1,1,2,3],[3,1,1,2]] over GF(2^4), polynomial x^4+x+1, applied to the nibble column with the MSB nibble first.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, the state register loads {X0^wk0, X1, X2^wk1, X3}.
  - wk2 and wk3 are latched, rk_round becomes 0, and the FSM moves to RUN.
- RUN, each edge with rk_round=i:
  - Y = {X0, X1^F(X0)^rk[31:16], X2, X3^F(X2)^rk[15:0]}.
  - If i<ROUNDS-1: state ← Roundpermutation(Y), i ← i+1.
  - If i=ROUNDS-1: no permutation. out_data ← {Y0^wk2, Y1, Y2^wk3, Y3}, out_valid ← 1, FSM moves to DONE.
  - in_valid is ignored during RUN.
- DONE:
  - out_valid and out_data are held stable until out_ready=1.
  - On that edge, out_valid ← 0 and the FSM moves to IDLE.
  - in_valid is ignored in DONE, even when out_ready is high in the same cycle.
- Latency: accept edge E0, out_valid high after edge E0+ROUNDS.
- Back-to-back throughput: one block per ROUNDS+2 cycles.
- rk_round is 0 in IDLE and DONE; it equals i throughout RUN.
- Arithmetic is XOR only; there is no carry and no overflow.

Optional Feature:
- Macro: PICCOLO_ROUND_ENGINE_DEC_EN.
- When defined, the engine adds an input port dec (1 bit), sampled on the accept edge.
- With dec=1:
  - Initial whitening uses wk2/wk3, final whitening uses wk0/wk1.
  - rk_round counts ROUNDS-1 down to 0.
  - On RUN steps where the step count is odd, the two rk halves are swapped before use. This implements the Piccolo decryption key ordering with the unchanged key schedule.
- With dec=0, and when the macro is undefined, behaviour is exactly encryption; the dec port does not exist when the macro is undefined.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles → in_ready=1 after release; out_valid=0, out_data=0, rk_round=0.
- Piccolo-80 known answer:
  - Stimulus: ROUNDS=25, in_data=64'h0123456789abcdef, wk=64'h0033221188776699, rk driven from the key-schedule model for key 80'h00112233445566778899.
  - Required: out_valid exactly 25 cycles after accept; out_data=64'h8d2bff9935f84056.
- Backpressure:
  - Stimulus: same vector as the known-answer test, out_ready=0 for 10 cycles, in_valid held high throughout.
  - Required: out_data stable; in_ready=0; second block accepted only after the out_ready handshake plus one cycle.
- Reset mid-operation: pull rst_n low at rk_round=12 → out_valid never asserts. The next block then produces the correct 64'h8d2bff9935f84056.
- Round index: monitor rk_round → 0..24 contiguous during RUN, no repeats, 0 in IDLE and DONE.
- With PICCOLO_ROUND_ENGINE_DEC_EN: in_data=64'h8d2bff9935f84056, dec=1, same key → out_data=64'h0123456789abcdef.
